// File: rtl/pond_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pond_pkg
// Description : Shared defaults, derived widths and the per-channel
//               configuration bundle for the N-dimensional pond buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package pond_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_DEPTH      = 32;
  localparam int DEF_NUM_DIMS   = 6;
  localparam int DEF_CW         = 16;

  // Derived widths: address bits and the width needed to hold 0..NUM_DIMS.
  localparam int DEF_AW = $clog2(DEF_DEPTH);
  localparam int DEF_DW = $clog2(DEF_NUM_DIMS + 1);

  // One channel's static configuration, sized for the default parameters.
  typedef struct packed {
    logic [DEF_DW-1:0]                      dimensionality;
    logic [DEF_NUM_DIMS-1:0][DEF_CW-1:0]    ranges;
    logic [DEF_AW-1:0]                      addr_start;
    logic [DEF_NUM_DIMS-1:0][DEF_AW-1:0]    addr_strides;
    logic [DEF_CW-1:0]                      sched_start;
    logic [DEF_NUM_DIMS-1:0][DEF_CW-1:0]    sched_strides;
  } chan_cfg_t;

endpackage
`default_nettype wire

// File: rtl/pond_nd_channel.sv
`default_nettype none
// ============================================================================
// Module      : pond_nd_channel
// Description : One access channel: N-dimensional iterator, address and
//               schedule generators, plus the active/done bookkeeping.
// Revision    : 1.0 - initial release
// ============================================================================
module pond_nd_channel
  import pond_pkg::*;
#(
  parameter int NUM_DIMS = DEF_NUM_DIMS,
  parameter int CW       = DEF_CW,
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW
) (
  input  logic                   gclk,
  input  logic                   rst_n,
  input  logic                   clk_en,
  input  logic                   flush,
  input  logic [CW-1:0]          cycle_count,
  input  logic [DW-1:0]          dimensionality,
  input  logic [NUM_DIMS*CW-1:0] ranges,
  input  logic [AW-1:0]          addr_start,
  input  logic [NUM_DIMS*AW-1:0] addr_strides,
  input  logic [CW-1:0]          sched_start,
  input  logic [NUM_DIMS*CW-1:0] sched_strides,
  output logic                   fire,
  output logic [AW-1:0]          addr,
  output logic                   done
);

  logic                         active;
  logic [NUM_DIMS-1:0][CW-1:0]  cnt;
  logic [AW-1:0]                addr_offset;
  logic [CW-1:0]                sched_offset;

  logic [NUM_DIMS-1:0]          lvl_onehot;
  logic [NUM_DIMS-1:0]          lower_mask;
  logic                         last;
  logic [AW-1:0]                addr_step;
  logic [CW-1:0]                sched_step;

  // Pick the lowest active level that has not yet reached its range.
  always_comb begin
    logic found;
    found      = 1'b0;
    lvl_onehot = '0;
    addr_step  = '0;
    sched_step = '0;
    for (int i = 0; i < NUM_DIMS; i++) begin
      if (!found && (DW'(i) < dimensionality) && (cnt[i] != ranges[i*CW +: CW])) begin
        found         = 1'b1;
        lvl_onehot[i] = 1'b1;
        addr_step     = addr_strides[i*AW +: AW];
        sched_step    = sched_strides[i*CW +: CW];
      end
    end
    last = !found;
  end

  // Every level below the selected one wraps back to zero.
  assign lower_mask = lvl_onehot - NUM_DIMS'(1);

  // Flush suppresses firing so the soft-reset cycle performs no access.
  assign fire = active && (dimensionality != '0) && !flush &&
                (cycle_count == sched_start + sched_offset);
  assign addr = addr_start + addr_offset;

  // Advance the iterator on each fire; the final fire retires the nest.
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      active       <= 1'b1;
      done         <= 1'b0;
      cnt          <= '0;
      addr_offset  <= '0;
      sched_offset <= '0;
    end else if (clk_en) begin
      if (flush) begin
        active       <= 1'b1;
        done         <= 1'b0;
        cnt          <= '0;
        addr_offset  <= '0;
        sched_offset <= '0;
      end else if (fire) begin
        if (last) begin
          active       <= 1'b0;
          done         <= 1'b1;
          cnt          <= '0;
          addr_offset  <= '0;
          sched_offset <= '0;
        end else begin
          for (int i = 0; i < NUM_DIMS; i++) begin
            if (lvl_onehot[i]) begin
              cnt[i] <= cnt[i] + CW'(1);
            end else if (lower_mask[i]) begin
              cnt[i] <= '0;
            end
          end
          addr_offset  <= addr_offset + addr_step;
          sched_offset <= sched_offset + sched_step;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pond_nd_rw.sv
`default_nettype none
// ============================================================================
// Module      : pond_nd_rw
// Description : N-dimensional pond: register-file buffer with one scheduled
//               write channel and one scheduled, registered read channel.
// Revision    : 1.0 - initial release
// ============================================================================
module pond_nd_rw
  import pond_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int DEPTH      = DEF_DEPTH,
  parameter  int NUM_DIMS   = DEF_NUM_DIMS,
  parameter  int CW         = DEF_CW,
  localparam int AW         = $clog2(DEPTH),
  localparam int DW         = $clog2(NUM_DIMS + 1)
) (
  input  logic                   gclk,
  input  logic                   rst_n,
  input  logic                   clk_en,
  input  logic                   flush,
  input  logic [DATA_WIDTH-1:0]  data_in,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   valid_out,
  output logic                   wr_done,
  output logic                   rd_done,
  input  logic [DW-1:0]          wr_dimensionality,
  input  logic [NUM_DIMS*CW-1:0] wr_ranges,
  input  logic [AW-1:0]          wr_addr_start,
  input  logic [NUM_DIMS*AW-1:0] wr_addr_strides,
  input  logic [CW-1:0]          wr_sched_start,
  input  logic [NUM_DIMS*CW-1:0] wr_sched_strides,
  input  logic [DW-1:0]          rd_dimensionality,
  input  logic [NUM_DIMS*CW-1:0] rd_ranges,
  input  logic [AW-1:0]          rd_addr_start,
  input  logic [NUM_DIMS*AW-1:0] rd_addr_strides,
  input  logic [CW-1:0]          rd_sched_start,
  input  logic [NUM_DIMS*CW-1:0] rd_sched_strides
);

  logic [CW-1:0]         cycle_count;
  logic                  wr_fire;
  logic                  rd_fire;
  logic [AW-1:0]         wr_addr;
  logic [AW-1:0]         rd_addr;
  logic                  bypass;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  pond_nd_channel #(
    .NUM_DIMS (NUM_DIMS),
    .CW       (CW),
    .AW       (AW),
    .DW       (DW)
  ) u_wr_chan (
    .gclk           (gclk),
    .rst_n          (rst_n),
    .clk_en         (clk_en),
    .flush          (flush),
    .cycle_count    (cycle_count),
    .dimensionality (wr_dimensionality),
    .ranges         (wr_ranges),
    .addr_start     (wr_addr_start),
    .addr_strides   (wr_addr_strides),
    .sched_start    (wr_sched_start),
    .sched_strides  (wr_sched_strides),
    .fire           (wr_fire),
    .addr           (wr_addr),
    .done           (wr_done)
  );

  pond_nd_channel #(
    .NUM_DIMS (NUM_DIMS),
    .CW       (CW),
    .AW       (AW),
    .DW       (DW)
  ) u_rd_chan (
    .gclk           (gclk),
    .rst_n          (rst_n),
    .clk_en         (clk_en),
    .flush          (flush),
    .cycle_count    (cycle_count),
    .dimensionality (rd_dimensionality),
    .ranges         (rd_ranges),
    .addr_start     (rd_addr_start),
    .addr_strides   (rd_addr_strides),
    .sched_start    (rd_sched_start),
    .sched_strides  (rd_sched_strides),
    .fire           (rd_fire),
    .addr           (rd_addr),
    .done           (rd_done)
  );

  // Free-running schedule time base, frozen by stall and zeroed by flush.
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
    end else if (clk_en) begin
      cycle_count <= flush ? '0 : cycle_count + CW'(1);
    end
  end

  // Storage write; contents deliberately survive reset and flush.
  always_ff @(posedge gclk) begin
    if (clk_en && wr_fire) begin
      mem[wr_addr] <= data_in;
    end
  end

  // A same-cycle write to the read address forwards the new word.
  assign bypass  = wr_fire && rd_fire && (wr_addr == rd_addr);
  assign rd_word = bypass ? data_in : mem[rd_addr];

  // Registered read port; valid_out strobes for exactly one enabled cycle.
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (clk_en) begin
      if (flush) begin
        valid_out <= 1'b0;
      end else if (rd_fire) begin
        data_out  <= rd_word;
        valid_out <= 1'b1;
      end else begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pond_nd_rw.sv
`default_nettype none
// ============================================================================
// Module      : tb_pond_nd_rw
// Description : Scoreboard bench for pond_nd_rw: directed nests push the
//               expected read words, a monitor pops them on valid_out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pond_nd_rw;
  import pond_pkg::*;

  logic        gclk;
  logic        rst_n;
  logic        clk_en;
  logic        flush;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        valid_out;
  logic        wr_done;
  logic        rd_done;
  chan_cfg_t   wr_cfg;
  chan_cfg_t   rd_cfg;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          tcyc   = 0;
  logic        last_en = 1'b0;
  int          mode   = 0;
  logic [15:0] const_val = 16'h0;
  int          exp_wd = -1;
  int          exp_rd = -1;

  pond_nd_rw dut (
    .gclk              (gclk),
    .rst_n             (rst_n),
    .clk_en            (clk_en),
    .flush             (flush),
    .data_in           (data_in),
    .data_out          (data_out),
    .valid_out         (valid_out),
    .wr_done           (wr_done),
    .rd_done           (rd_done),
    .wr_dimensionality (wr_cfg.dimensionality),
    .wr_ranges         (wr_cfg.ranges),
    .wr_addr_start     (wr_cfg.addr_start),
    .wr_addr_strides   (wr_cfg.addr_strides),
    .wr_sched_start    (wr_cfg.sched_start),
    .wr_sched_strides  (wr_cfg.sched_strides),
    .rd_dimensionality (rd_cfg.dimensionality),
    .rd_ranges         (rd_cfg.ranges),
    .rd_addr_start     (rd_cfg.addr_start),
    .rd_addr_strides   (rd_cfg.addr_strides),
    .rd_sched_start    (rd_cfg.sched_start),
    .rd_sched_strides  (rd_cfg.sched_strides)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  // Remember whether the last edge was enabled so a held strobe counts once.
  always @(posedge gclk) last_en <= clk_en;

  // Monitor: every fresh valid_out strobe must match the queue head.
  always @(negedge gclk) begin
    if (rst_n === 1'b1 && last_en && valid_out === 1'b1) begin
      exp_t e;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected got data=%h at cyc %0d need no read", data_out, tcyc);
      end else begin
        e = sbq.pop_front();
        if (data_out !== e.data || tcyc != e.cyc) begin
          errors++;
          $display("FAIL read_data got %h at cyc %0d need %h at cyc %0d",
                   data_out, tcyc, e.data, e.cyc);
        end
      end
    end
  end

  function automatic chan_cfg_t mk(int dims, int r0, int r1, int as, int ad0, int ad1,
                                   int ss, int sd0, int sd1);
    chan_cfg_t c;
    c                  = '0;
    c.dimensionality   = DEF_DW'(dims);
    c.ranges[0]        = DEF_CW'(r0);
    c.ranges[1]        = DEF_CW'(r1);
    c.addr_start       = DEF_AW'(as);
    c.addr_strides[0]  = DEF_AW'(ad0);
    c.addr_strides[1]  = DEF_AW'(ad1);
    c.sched_start      = DEF_CW'(ss);
    c.sched_strides[0] = DEF_CW'(sd0);
    c.sched_strides[1] = DEF_CW'(sd1);
    return c;
  endfunction

  function automatic logic [15:0] dval(int c);
    case (mode)
      0:       return 16'(100 + c);
      1:       return 16'(32'h200 + c);
      2:       return const_val;
      default: return 16'(32'h400 + c);
    endcase
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h need %h", name, got, want);
    end
  endtask

  task automatic push(logic [15:0] d, int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    sbq.push_back(e);
  endtask

  // One clock: mirror the schedule counter, present data, check done flags.
  task automatic tick();
    @(posedge gclk);
    #1;
    if (clk_en) tcyc = flush ? 0 : tcyc + 1;
    data_in = dval(tcyc);
    if (rst_n) begin
      check("wr_done", 32'(wr_done), 32'(exp_wd >= 0 && tcyc >= exp_wd));
      check("rd_done", 32'(rd_done), 32'(exp_rd >= 0 && tcyc >= exp_rd));
    end
  endtask

  task automatic start();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic run_to(int n);
    int guard;
    guard = 0;
    while (tcyc < n && guard < 2000) begin
      tick();
      guard++;
    end
    if (guard >= 2000) check("run_timeout", 32'(tcyc), 32'(n));
  endtask

  task automatic drained(string name);
    check(name, 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    clk_en  = 1'b1;
    flush   = 1'b0;
    data_in = 16'h0;
    wr_cfg  = '0;
    rd_cfg  = '0;
    repeat (2) @(posedge gclk);
    #1;
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_wr_done", 32'(wr_done), 32'd0);
    check("rst_rd_done", 32'(rd_done), 32'd0);
    rst_n = 1'b1;
    tcyc  = 0;

    // Linear stream
    mode   = 0;
    wr_cfg = mk(1, 7, 0, 0, 1, 0, 0, 1, 0);
    rd_cfg = mk(1, 7, 0, 0, 1, 0, 10, 1, 0);
    exp_wd = 8;
    exp_rd = 18;
    for (int i = 0; i < 8; i++) push(16'(100 + i), 11 + i);
    start();
    run_to(20);
    drained("linear_drained");

    // 2-D transpose
    mode   = 1;
    wr_cfg = mk(2, 3, 3, 0, 1, 1, 0, 1, 1);
    rd_cfg = mk(2, 3, 3, 0, 4, 21, 20, 1, 1);
    exp_wd = 16;
    exp_rd = 36;
    for (int k = 0; k < 16; k++) push(16'(32'h200 + (k % 4) * 4 + k / 4), 21 + k);
    start();
    run_to(40);
    drained("transpose_drained");

    // Bypass: preload addr 3 with 0x1111, then collide write and read there
    mode      = 2;
    const_val = 16'h1111;
    wr_cfg    = mk(1, 0, 0, 3, 0, 0, 2, 0, 0);
    rd_cfg    = '0;
    exp_wd    = 3;
    exp_rd    = -1;
    start();
    run_to(5);
    const_val = 16'hBEEF;
    wr_cfg    = mk(1, 0, 0, 3, 0, 0, 5, 0, 0);
    rd_cfg    = mk(1, 1, 0, 3, 0, 0, 5, 3, 0);
    exp_wd    = 6;
    exp_rd    = 9;
    push(16'hBEEF, 6);
    push(16'hBEEF, 9);
    start();
    run_to(12);
    drained("bypass_drained");

    // Wrap-around writes at 30,31,0,1
    mode   = 3;
    wr_cfg = mk(1, 3, 0, 30, 1, 0, 0, 1, 0);
    rd_cfg = mk(1, 3, 0, 30, 1, 0, 6, 1, 0);
    exp_wd = 4;
    exp_rd = 10;
    for (int i = 0; i < 4; i++) push(16'(32'h400 + i), 7 + i);
    start();
    run_to(12);
    drained("wrap_drained");
    rd_cfg = mk(1, 1, 0, 0, 1, 0, 6, 1, 0);
    exp_rd = 8;
    push(16'h0402, 7);
    push(16'h0403, 8);
    start();
    run_to(10);
    drained("wrap_low_drained");

    // Stall mid-read, then flush and rerun
    mode   = 0;
    wr_cfg = mk(1, 7, 0, 0, 1, 0, 0, 1, 0);
    rd_cfg = mk(1, 7, 0, 0, 1, 0, 10, 1, 0);
    exp_wd = 8;
    exp_rd = 18;
    for (int i = 0; i < 8; i++) push(16'(100 + i), 11 + i);
    start();
    run_to(13);
    clk_en = 1'b0;
    repeat (3) begin
      tick();
      check("stall_valid_hold", 32'(valid_out), 32'd1);
      check("stall_data_hold", 32'(data_out), 32'd102);
    end
    clk_en = 1'b1;
    run_to(20);
    drained("stall_drained");
    start();
    check("flush_wr_done", 32'(wr_done), 32'd0);
    check("flush_rd_done", 32'(rd_done), 32'd0);
    for (int i = 0; i < 8; i++) push(16'(100 + i), 11 + i);
    run_to(20);
    drained("rerun_drained");

    // Asynchronous reset in the middle of the read nest
    for (int i = 0; i < 8; i++) push(16'(100 + i), 11 + i);
    start();
    run_to(14);
    @(negedge gclk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_data_out", 32'(data_out), 32'd0);
    check("arst_valid_out", 32'(valid_out), 32'd0);
    check("arst_wr_done", 32'(wr_done), 32'd0);
    check("arst_rd_done", 32'(rd_done), 32'd0);
    check("arst_pending_reads", 32'(sbq.size()), 32'd4);
    sbq.delete();
    @(posedge gclk);
    #1;
    rst_n   = 1'b1;
    tcyc    = 0;
    data_in = dval(0);
    for (int i = 0; i < 8; i++) push(16'(100 + i), 11 + i);
    run_to(20);
    drained("arst_restart_drained");

    // Zero dimensionality never fires
    wr_cfg = mk(0, 7, 0, 0, 1, 0, 0, 1, 0);
    rd_cfg = mk(0, 7, 0, 0, 1, 0, 0, 1, 0);
    exp_wd = -1;
    exp_rd = -1;
    start();
    run_to(100);
    drained("dims0_drained");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
